// File: rtl/mipi_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the software/bridge side.
// master drives the reset request; slave is the sequencer itself.
interface mipi_reset_sequencer_if;
    logic       rst_req_n;
    logic       mipi_rst_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] seq_count;

    modport master (
        output rst_req_n,
        input  mipi_rst_n,
        input  ready,
        input  state,
        input  seq_count
    );

    modport slave (
        input  rst_req_n,
        output mipi_rst_n,
        output ready,
        output state,
        output seq_count
    );
endinterface

// File: rtl/mipi_reset_sequencer.sv
// Power-up / software-requested reset sequencing for a MIPI bridge: hold reset
// for a minimum width, release it, then wait a fixed wake time before ready.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RST   | bridge held in reset; cnt counts up, saturating at T_RST_CYC
// ST_WAKE  | reset released; cnt counts the wake time
// ST_READY | wake time elapsed; I2C configuration may start; cnt holds
module mipi_reset_sequencer #(
    parameter int unsigned T_RST_CYC  = 1000,
    parameter int unsigned T_WAKE_CYC = 5000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mipi_reset_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_CYC);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(T_WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    logic             req_m;
    logic             req_s;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       seq_q;
    logic [7:0]       seq_nxt;
    logic             mipi_rst_n_q;
    logic             mipi_rst_n_nxt;
    logic             ready_q;
    logic             ready_nxt;

    // Request is written by software in another domain; resync before use.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= bus.rst_req_n;
            req_s <= req_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RST;
            cnt_q        <= CNT_ZERO;
            seq_q        <= 8'd0;
            mipi_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            seq_q        <= seq_nxt;
            mipi_rst_n_q <= mipi_rst_n_nxt;
            ready_q      <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        seq_nxt   = seq_q;

        case (state_q)
            ST_RST: begin
                // Early request release only arms the exit; the minimum
                // reset width is always served first.
                if (cnt_q >= RST_LAST) begin
                    if (req_s) begin
                        state_nxt = ST_WAKE;
                        cnt_nxt   = CNT_ZERO;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end

            ST_WAKE: begin
                // A new reset request wins over completing the wake time.
                if (!req_s) begin
                    state_nxt = ST_RST;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt_q == WAKE_LAST) begin
                    state_nxt = ST_READY;
                    seq_nxt   = seq_q + 8'd1;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end

            ST_READY: begin
                if (!req_s) begin
                    state_nxt = ST_RST;
                    cnt_nxt   = CNT_ZERO;
                end
            end

            default: begin
                state_nxt = ST_RST;
                cnt_nxt   = CNT_ZERO;
            end
        endcase

        // Outputs are registered from the next state so they never glitch.
        mipi_rst_n_nxt = (state_nxt != ST_RST);
        ready_nxt      = (state_nxt == ST_READY);
    end

    assign bus.mipi_rst_n = mipi_rst_n_q;
    assign bus.ready      = ready_q;
    assign bus.state      = state_q;
    assign bus.seq_count  = seq_q;

endmodule

// File: tb/tb_mipi_reset_sequencer.sv
// Scoreboard bench for mipi_reset_sequencer: a timestamp-level reference model
// predicts every output change; a monitor checks DUT changes against it.
module tb_mipi_reset_sequencer;

    localparam int T_RST  = 4;
    localparam int T_WAKE = 6;

    logic clk;
    logic reset_n;

    mipi_reset_sequencer_if bus();

    mipi_reset_sequencer #(
        .T_RST_CYC (T_RST),
        .T_WAKE_CYC(T_WAKE),
        .CNT_W     (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [11:0] tup;
    } ev_t;

    ev_t exp_q[$];

    int  vectors     = 0;
    int  miscompares = 0;
    int  tmo_errs    = 0;
    bit  end_req     = 1'b0;
    bit  end_ack     = 1'b0;

    // Reference model: time since entering a phase, spec-level rules.
    int          edge_cnt;
    int          m_phase;
    int          m_entered;
    int          m_seq;
    bit          hist[$];
    logic [11:0] m_prev;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt  = 0;
            m_phase   = 0;
            m_entered = 0;
            m_seq     = 0;
            hist.delete();
            m_prev    = 12'h000;
        end else begin
            bit          rs;
            logic [11:0] t;
            ev_t         ev;
            edge_cnt = edge_cnt + 1;
            rs = (hist.size() == 2) ? hist[0] : 1'b0;
            case (m_phase)
                0: if ((edge_cnt - m_entered) >= T_RST + 1 && rs) begin
                       m_phase   = 1;
                       m_entered = edge_cnt;
                   end
                1: if (!rs) begin
                       m_phase   = 0;
                       m_entered = edge_cnt;
                   end else if (edge_cnt - m_entered == T_WAKE) begin
                       m_phase = 2;
                       m_seq   = (m_seq + 1) % 256;
                   end
                default: if (!rs) begin
                       m_phase   = 0;
                       m_entered = edge_cnt;
                   end
            endcase
            hist.push_back(bus.rst_req_n);
            if (hist.size() > 2) void'(hist.pop_front());
            t = {m_phase != 0, m_phase == 2, 2'(m_phase), 8'(m_seq)};
            if (t != m_prev) begin
                ev.edge_n = edge_cnt;
                ev.tup    = t;
                exp_q.push_back(ev);
                m_prev = t;
            end
        end
    end

    // Monitor: every observed output change must match the next prediction.
    logic [11:0] last_obs = 12'h000;

    always @(negedge clk) begin
        logic [11:0] cur;
        ev_t         ev;
        cur = {bus.mipi_rst_n, bus.ready, bus.state, bus.seq_count};
        if (!reset_n) begin
            vectors++;
            if (cur !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_state: got %03h required 000", cur);
            end
            exp_q.delete();
            last_obs = 12'h000;
        end else begin
            if (cur !== last_obs) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change edge %0d: got %03h required %03h",
                             edge_cnt, cur, last_obs);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.tup !== cur || ev.edge_n != edge_cnt) begin
                        miscompares++;
                        $display("FAIL output_change: got %03h at edge %0d required %03h at edge %0d",
                                 cur, edge_cnt, ev.tup, ev.edge_n);
                    end
                end
                last_obs = cur;
            end
            if (end_req && !end_ack) begin
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL missing_change: %0d predicted changes never seen, required 0",
                             exp_q.size());
                end
                vectors++;
                if (tmo_errs != 0) begin
                    miscompares++;
                    $display("FAIL wait_budget: %0d waits expired, required 0", tmo_errs);
                end
                end_ack = 1'b1;
            end
        end
    end

    task automatic hold(input bit v, input int n);
        bus.rst_req_n = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input int maxc);
        int k = 0;
        while (!bus.ready && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ready) begin
            tmo_errs++;
            $display("FAIL wait_ready: ready=%0b required 1 within %0d cycles", bus.ready, maxc);
        end
    endtask

    task automatic wait_mipi(input bit lvl, input int maxc);
        int k = 0;
        while (bus.mipi_rst_n !== lvl && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (bus.mipi_rst_n !== lvl) begin
            tmo_errs++;
            $display("FAIL wait_mipi: mipi_rst_n=%0b required %0b within %0d cycles",
                     bus.mipi_rst_n, lvl, maxc);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.rst_req_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Request released from reset: release at edge 5, ready at edge 11.
        wait_ready(40);
        hold(1'b1, 3);

        // Single-cycle request pulse while ready.
        hold(1'b0, 1);
        bus.rst_req_n = 1'b1;
        wait_ready(40);
        hold(1'b1, 2);

        // Abort wake so req_s drops on the edge where cnt == T_WAKE-1.
        hold(1'b0, 1);
        bus.rst_req_n = 1'b1;
        wait_mipi(1'b0, 10);
        wait_mipi(1'b1, 20);
        repeat (3) @(negedge clk);
        hold(1'b0, 2);
        hold(1'b1, 20);
        wait_ready(40);

        // Request held low for 100 cycles after reset.
        bus.rst_req_n = 1'b0;
        do_reset(2);
        hold(1'b0, 100);
        bus.rst_req_n = 1'b1;
        wait_ready(40);

        // Random request activity.
        repeat (150) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            hold(v, v ? $urandom_range(1, 16) : $urandom_range(1, 4));
        end
        hold(1'b1, 2);

        // 256 complete sequences from a clean reset wrap seq_count to 0.
        bus.rst_req_n = 1'b1;
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            wait_ready(40);
            hold(1'b1, 1);
            hold(1'b0, 1);
            bus.rst_req_n = 1'b1;
        end
        wait_mipi(1'b0, 10);
        wait_mipi(1'b1, 20);
        hold(1'b1, 2);

        // Asynchronous reset in the middle of wake.
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hold(1'b1, 20);

        end_req = 1'b1;
        begin
            int k = 0;
            while (!end_ack && k < 10) begin
                @(negedge clk);
                k++;
            end
        end
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor ack=%0b required 1", end_ack);
            $fatal(1, "monitor did not finish");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
